// File: rtl/clk_sched_pkg.sv
// Shared types and default sizing for the derived-clock window scheduler.
package clk_sched_pkg;
  typedef enum logic [1:0] {IDLE, GUARD_PRE, RUN, GUARD_POST} state_t;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_LEN_W  = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/clk_gate_sched.sv
// Shares one derived-clock generator between requesters: guard, run window, guard,
// then a completion pulse to the owner. Outputs are registered from next-state.
module clk_gate_sched
  import clk_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     abort,
  output logic                     inv_reset,
  output logic                     gate_en,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [N_REQ-1:0]         done
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_cnt, len_cnt_nx, len_sel;
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic [IW-1:0]    ptr, ptr_nx, gidx, owner_nx;
  logic [N_REQ-1:0] grant, done_nx;
  logic             hs;
  logic [LEN_W-1:0] lens [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_len
    assign lens[i] = req_len[i*LEN_W +: LEN_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx)
  );

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign hs        = |(req_ready & req_valid);
  assign len_sel   = lens[gidx];

  always_comb begin
    state_nx   = state;
    len_cnt_nx = len_cnt;
    gcnt_nx    = gcnt;
    ptr_nx     = ptr;
    owner_nx   = owner;
    done_nx    = '0;
    case (state)
      IDLE: if (hs) begin
        ptr_nx   = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
        owner_nx = gidx;
        if (len_sel != '0) begin
          state_nx   = GUARD_PRE;
          len_cnt_nx = len_sel;
          gcnt_nx    = GW'(SETTLE - 1);
        end else begin
          done_nx[gidx] = 1'b1;  // zero-length window completes without touching the gate
        end
      end
      GUARD_PRE: begin
        if (gcnt == '0) state_nx = RUN;
        else            gcnt_nx  = gcnt - GW'(1);
      end
      RUN: begin
        if (len_cnt == LEN_W'(1) || abort) begin
          state_nx   = GUARD_POST;
          len_cnt_nx = '0;
          gcnt_nx    = GW'(SETTLE - 1);
        end else begin
          len_cnt_nx = len_cnt - LEN_W'(1);
        end
      end
      GUARD_POST: begin
        if (gcnt == '0) begin
          state_nx       = IDLE;
          done_nx[owner] = 1'b1;
        end else begin
          gcnt_nx = gcnt - GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_cnt   <= '0;
      gcnt      <= '0;
      ptr       <= '0;
      owner     <= '0;
      done      <= '0;
      gate_en   <= 1'b0;
      inv_reset <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      len_cnt   <= len_cnt_nx;
      gcnt      <= gcnt_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      done      <= done_nx;
      gate_en   <= (state_nx == RUN);
      inv_reset <= (state_nx != RUN);
      busy      <= (state_nx != IDLE);
    end
  end
endmodule

// File: tb/tb_clk_gate_sched.sv
// Bench for clk_gate_sched: timeline model compared every cycle plus directed literal checks.
module tb_clk_gate_sched;
  localparam int N = 4, LW = 16, ST = 2;

  logic          clk = 1'b0, reset = 1'b1, abort = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]  req_ready, done;
  logic          inv_reset, gate_en, busy;
  logic [1:0]    owner;

  int     checks = 0, errors = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;

  // model: the current window expressed as absolute cycle intervals
  longint pre_s = 1, run_s = 1, run_e = 0, post_e = 0, done_c = -1, free_at = 0;
  int     m_ptr = 0, m_owner = 0, d_owner = 0;
  logic [N-1:0] hs_mask = '0;

  clk_gate_sched #(.N_REQ(N), .LEN_W(LW), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .abort(abort), .inv_reset(inv_reset),
    .gate_en(gate_en), .owner(owner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    longint L;
    logic [N-1:0] er, ed;
    logic eg, eb;
    w  = (!reset && cyc >= free_at) ? rr_pick(req_valid, m_ptr) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    ed = '0;
    if (cyc == done_c) ed[d_owner] = 1'b1;
    eg = (cyc >= run_s && cyc <= run_e);
    eb = (cyc >= pre_s && cyc <= post_e);
    if (chk_en) begin
      chk("req_ready", req_ready, er);
      chk("gate_en", gate_en, eg);
      chk("inv_reset", inv_reset, !eg);
      chk("busy", busy, eb);
      chk("owner", owner, m_owner);
      chk("done", done, ed);
    end
    hs_mask = er;
    if (reset) begin
      pre_s = 1; post_e = 0; run_s = 1; run_e = 0; done_c = -1;
      m_owner = 0; m_ptr = 0; free_at = cyc + 1;
    end else if (w >= 0) begin
      L = longint'(req_len[w*LW +: LW]);
      m_owner = w; d_owner = w; m_ptr = (w + 1) % N;
      if (L == 0) begin
        done_c = cyc + 1; free_at = cyc + 1;
      end else begin
        pre_s  = cyc + 1;
        run_s  = cyc + ST + 1;
        run_e  = cyc + ST + L;
        post_e = run_e + ST;
        done_c = post_e + 1;
        free_at = done_c;
      end
    end else if (abort && cyc >= run_s && cyc <= run_e) begin
      run_e = cyc; post_e = cyc + ST; done_c = post_e + 1; free_at = done_c;
    end
  end

  // inputs change 1 time unit after the active edge; accepted requests drop valid
  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~hs_mask;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1; req_valid = '0; abort = 1'b0;
    tick(); reset = 1'b0;
  endtask

  int q[$];
  int n, gcount;
  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    tick(); tick(); reset = 1'b0; chk_en = 1'b1;
    #2;
    chk("rst_gate", gate_en, 0); chk("rst_inv", inv_reset, 1);
    chk("rst_busy", busy, 0); chk("rst_owner", owner, 0); chk("rst_done", done, 0);

    // single request, len 5
    tick(); set_len(0, 5); req_valid = 4'b0001; #2;
    chk("t1_ready", req_ready, 4'b0001);
    for (int k = 1; k <= 10; k++) begin
      tick(); #2;
      chk("t1_gate", gate_en, (k >= 3 && k <= 7));
      chk("t1_busy", busy, (k >= 1 && k <= 9));
      chk("t1_done", done, (k == 10) ? 4'b0001 : 4'b0000);
    end

    // simultaneous req 0 and 2, len 1
    do_reset();
    tick(); set_len(0, 1); set_len(2, 1); req_valid = 4'b0101; #2;
    chk("t2_ready0", req_ready, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      tick(); #2;
      chk("t2_gate", gate_en, (k == 3 || k == 9));
      chk("t2_done", done, (k == 6) ? 4'b0001 : (k == 12) ? 4'b0100 : 4'b0000);
      if (k == 6) chk("t2_ready2", req_ready, 4'b0100);
    end

    // all requesters continuously asking, len 1
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 1);
    n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      tick(); req_valid = 4'hF; #2;
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) begin q.push_back(i); n++; end
    end
    chk("t3_grants", n, 6);
    for (int i = 0; i < 6 && i < q.size(); i++) chk("t3_order", q[i], order[i]);

    // zero length on req 1
    do_reset();
    tick(); set_len(1, 0); req_valid = 4'b0010; #2;
    chk("t4_ready", req_ready, 4'b0010);
    tick(); #2;
    chk("t4_done", done, 4'b0010); chk("t4_busy", busy, 0);
    chk("t4_gate", gate_en, 0); chk("t4_inv", inv_reset, 1);
    tick(); #2;
    chk("t4_done_off", done, 0);

    // abort in 3rd RUN cycle; abort during GUARD_PRE must be ignored
    do_reset();
    tick(); set_len(3, 10); req_valid = 4'b1000; #2;
    chk("t5_ready", req_ready, 4'b1000);
    gcount = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(); abort = (k == 1 || k == 5); #2;
      if (gate_en === 1'b1) gcount++;
      if (k == 7) chk("t5_post_busy", busy, 1);
      if (k == 8) begin chk("t5_done", done, 4'b1000); chk("t5_idle", busy, 0); end
    end
    abort = 1'b0;
    chk("t5_gate_cycles", gcount, 3);

    // reset mid-RUN, then a fresh window completes
    do_reset();
    tick(); set_len(1, 8); req_valid = 4'b0010;
    for (int k = 1; k <= 4; k++) tick();
    #2; chk("t6_run", gate_en, 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; #2;
    chk("t6_gate", gate_en, 0); chk("t6_inv", inv_reset, 1);
    chk("t6_busy", busy, 0); chk("t6_owner", owner, 0); chk("t6_done", done, 0);
    for (int k = 0; k < 6; k++) tick();
    tick(); set_len(2, 2); req_valid = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick(); #2;
      if (k == 1) chk("t6_owner2", owner, 2);
      if (k == 7) chk("t6_done2", done, 4'b0100);
    end

    // mixed traffic: short/zero lengths, lengths changing while pending, stray aborts
    do_reset();
    for (int k = 0; k < 300; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
        set_len(i, $urandom_range(0, 4));
      end
      abort = ($urandom_range(0, 7) == 0);
    end
    abort = 1'b0;
    do_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
